// File: rtl/spi_ctrl_pkg.sv
// Shared SPI controller definitions: frame FSM states, SPI mode encodings
// and the run-enable rule also used by the slave-select block.
package spi_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [1:0] SPI_MODE_RUN  = 2'b00;
    localparam logic [1:0] SPI_MODE_WAIT = 2'b01;

    // Wait mode keeps running unless stop-in-wait is set; any other mode stops.
    function automatic logic run_en(input logic       mstr,
                                    input logic       spiswai,
                                    input logic [1:0] spi_mode);
        return mstr & ((spi_mode == SPI_MODE_RUN) |
                       ((spi_mode == SPI_MODE_WAIT) & ~spiswai));
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick of the first request at or
// after the pointer, with the pointer moving past the winner on each grant.
module spi_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            valid,
    output logic [IW-1:0]   ptr
);

    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!valid && req[j]) begin
                valid     = 1'b1;
                grant_idx = IW'(j);
                grant[j]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && valid) begin
            ptr <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Per-frame SPI controller: arbitrates requesters, launches one frame on the
// datapath, returns RX data with done/err to the owner, then holds a frame gap.
module spi_xfer_sequencer #(
    parameter int NREQ  = 2,
    parameter int DW    = 8,
    parameter int TO_W  = 16,
    parameter int GAP_W = 4
) (
    input  logic               PCLK,
    input  logic               PRESET_n,
    input  logic               mstr_i,
    input  logic               spiswai_i,
    input  logic [1:0]         spi_mode_i,
    input  logic [TO_W-1:0]    timeout_i,
    input  logic [GAP_W-1:0]   gap_i,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*DW-1:0] tx_data_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    done_o,
    output logic               err_o,
    output logic [DW-1:0]      rx_data_o,
    output logic               send_data_o,
    output logic [DW-1:0]      mosi_data_o,
    input  logic               receive_data_i,
    input  logic [DW-1:0]      miso_data_i,
    output logic               busy_o
);

    import spi_ctrl_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state;
    state_t            state_next;
    logic              run;
    logic              grant_take;
    logic              frame_end;
    logic              frame_err;
    logic              timed_out;
    logic [NREQ-1:0]   pick_grant;
    logic [IW-1:0]     pick_idx;
    logic              pick_valid;
    logic [IW-1:0]     rr_ptr;
    logic [NREQ-1:0]   owner_mask;
    logic [TO_W-1:0]   to_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    assign run       = run_en(mstr_i, spiswai_i, spi_mode_i);
    assign timed_out = (timeout_i != '0) && (to_cnt == timeout_i - TO_W'(1));
    assign busy_o    = (state != IDLE);

    spi_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arbiter (
        .clk       (PCLK),
        .rst_n     (PRESET_n),
        .req       (req_i),
        .advance   (grant_take),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .valid     (pick_valid),
        .ptr       (rr_ptr)
    );

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A receive in the same cycle as an abort or timeout still completes cleanly.
    always_comb begin
        state_next = state;
        grant_take = 1'b0;
        frame_end  = 1'b0;
        frame_err  = 1'b0;
        case (state)
            IDLE: begin
                if (run && pick_valid) begin
                    grant_take = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (receive_data_i) begin
                    frame_end  = 1'b1;
                    state_next = GAP;
                end else if (!run || timed_out) begin
                    frame_end  = 1'b1;
                    frame_err  = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            gnt_o       <= '0;
            done_o      <= '0;
            err_o       <= 1'b0;
            send_data_o <= 1'b0;
            rx_data_o   <= '0;
            mosi_data_o <= '0;
            owner_mask  <= '0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
        end else begin
            gnt_o       <= '0;
            done_o      <= '0;
            err_o       <= 1'b0;
            send_data_o <= 1'b0;
            if (grant_take) begin
                gnt_o       <= pick_grant;
                owner_mask  <= pick_grant;
                mosi_data_o <= tx_data_i[int'(pick_idx)*DW +: DW];
            end
            if (state == SEND) begin
                send_data_o <= 1'b1;
                to_cnt      <= '0;
            end
            if (state == WAIT && to_cnt != '1) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            // Aborted frames keep the previous RX byte visible.
            if (frame_end) begin
                done_o  <= owner_mask;
                err_o   <= frame_err;
                gap_cnt <= gap_i;
                if (!frame_err) begin
                    rx_data_o <= miso_data_i;
                end
            end
            if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed self-checking bench for spi_xfer_sequencer (NREQ=2, DW=8).
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_spi_xfer_sequencer;

   logic        PCLK;
   logic        PRESET_n;
   logic        mstr_i;
   logic        spiswai_i;
   logic [1:0]  spi_mode_i;
   logic [15:0] timeout_i;
   logic [3:0]  gap_i;
   logic [1:0]  req_i;
   logic [15:0] tx_data_i;
   logic [1:0]  gnt_o;
   logic [1:0]  done_o;
   logic        err_o;
   logic [7:0]  rx_data_o;
   logic        send_data_o;
   logic [7:0]  mosi_data_o;
   logic        receive_data_i;
   logic [7:0]  miso_data_i;
   logic        busy_o;

   int errors = 0;
   int checks = 0;

   spi_xfer_sequencer #(
      .NREQ (2),
      .DW   (8),
      .TO_W (16),
      .GAP_W(4)
   ) dut (
      .PCLK           (PCLK),
      .PRESET_n       (PRESET_n),
      .mstr_i         (mstr_i),
      .spiswai_i      (spiswai_i),
      .spi_mode_i     (spi_mode_i),
      .timeout_i      (timeout_i),
      .gap_i          (gap_i),
      .req_i          (req_i),
      .tx_data_i      (tx_data_i),
      .gnt_o          (gnt_o),
      .done_o         (done_o),
      .err_o          (err_o),
      .rx_data_o      (rx_data_o),
      .send_data_o    (send_data_o),
      .mosi_data_o    (mosi_data_o),
      .receive_data_i (receive_data_i),
      .miso_data_i    (miso_data_i),
      .busy_o         (busy_o)
   );

   // Free-running 100MHz clock.
   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // Every comparison goes through here so pass/fail counts stay consistent.
   task automatic checkOutput(input bit ok, input string msg);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL %s", msg);
      end
   endtask

   task automatic test_reset();
      PRESET_n       = 1'b0;
      mstr_i         = 1'b1;
      spiswai_i      = 1'b0;
      spi_mode_i     = 2'b00;
      timeout_i      = 16'd0;
      gap_i          = 4'd0;
      req_i          = 2'b00;
      tx_data_i      = 16'h0000;
      receive_data_i = 1'b0;
      miso_data_i    = 8'h00;
      tick();
      tick();
      checkOutput({gnt_o, done_o, err_o, send_data_o, busy_o} === 7'b0,
                  $sformatf("reset_flags: got gnt=%b done=%b err=%b send=%b busy=%b want all 0",
                            gnt_o, done_o, err_o, send_data_o, busy_o));
      checkOutput({rx_data_o, mosi_data_o} === 16'h0000,
                  $sformatf("reset_data: got rx=%h mosi=%h want 00 00", rx_data_o, mosi_data_o));
      PRESET_n = 1'b1;
      tick();
      tick();
      checkOutput(gnt_o === 2'b00 && busy_o === 1'b0,
                  $sformatf("idle_no_req: got gnt=%b busy=%b want 00 0", gnt_o, busy_o));
   endtask

   task automatic test_single();
      logic early_done;
      early_done = 1'b0;
      tx_data_i = {8'h00, 8'hA5};
      req_i     = 2'b01;
      tick();
      checkOutput(gnt_o === 2'b01 && mosi_data_o === 8'hA5 && send_data_o === 1'b0 && busy_o === 1'b1,
                  $sformatf("t1_grant: got gnt=%b mosi=%h send=%b busy=%b want 01 a5 0 1",
                            gnt_o, mosi_data_o, send_data_o, busy_o));
      req_i = 2'b00;
      tick();
      checkOutput(send_data_o === 1'b1 && gnt_o === 2'b00,
                  $sformatf("t1_send: got send=%b gnt=%b want 1 00", send_data_o, gnt_o));
      repeat (19) begin
         tick();
         if (done_o !== 2'b00 || send_data_o !== 1'b0) early_done = 1'b1;
      end
      checkOutput(!early_done, "t1_quiet_wait: got early done/send want none before receive");
      receive_data_i = 1'b1;
      miso_data_i    = 8'h3C;
      tick();
      receive_data_i = 1'b0;
      miso_data_i    = 8'h00;
      checkOutput(done_o === 2'b01 && err_o === 1'b0 && rx_data_o === 8'h3C,
                  $sformatf("t1_done: got done=%b err=%b rx=%h want 01 0 3c", done_o, err_o, rx_data_o));
      tick();
      checkOutput(done_o === 2'b00 && busy_o === 1'b0 && rx_data_o === 8'h3C && mosi_data_o === 8'hA5,
                  $sformatf("t1_after: got done=%b busy=%b rx=%h mosi=%h want 00 0 3c a5",
                            done_o, busy_o, rx_data_o, mosi_data_o));
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_order [4];
      logic [7:0] exp_mosi;
      int n;
      exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
      PRESET_n = 1'b0;
      tick();
      PRESET_n  = 1'b1;
      gap_i     = 4'd0;
      tx_data_i = {8'h22, 8'h11};
      req_i     = 2'b11;
      for (int f = 0; f < 4; f++) begin
         n = 0;
         tick();
         while (gnt_o === 2'b00 && n < 10) begin
            tick();
            n++;
         end
         exp_mosi = (exp_order[f] == 2'b01) ? 8'h11 : 8'h22;
         checkOutput(gnt_o === exp_order[f] && mosi_data_o === exp_mosi,
                     $sformatf("t2_grant%0d: got gnt=%b mosi=%h want %b %h",
                               f, gnt_o, mosi_data_o, exp_order[f], exp_mosi));
         tick();
         receive_data_i = 1'b1;
         miso_data_i    = 8'h40 + 8'(f);
         tick();
         receive_data_i = 1'b0;
         checkOutput(done_o === exp_order[f] && err_o === 1'b0 && rx_data_o === 8'h40 + 8'(f),
                     $sformatf("t2_done%0d: got done=%b err=%b rx=%h want %b 0 %h",
                               f, done_o, err_o, rx_data_o, exp_order[f], 8'h40 + 8'(f)));
      end
      req_i = 2'b00;
      tick();
      tick();
   endtask

   task automatic test_timeout();
      int n;
      timeout_i = 16'd8;
      tx_data_i = {8'h00, 8'h6B};
      req_i     = 2'b01;
      tick();
      checkOutput(gnt_o === 2'b01 && mosi_data_o === 8'h6B,
                  $sformatf("t3_grant: got gnt=%b mosi=%h want 01 6b", gnt_o, mosi_data_o));
      req_i = 2'b00;
      tick();
      checkOutput(send_data_o === 1'b1,
                  $sformatf("t3_send: got send=%b want 1", send_data_o));
      n = 0;
      while (done_o === 2'b00 && n < 20) begin
         tick();
         n++;
      end
      checkOutput(n == 8, $sformatf("t3_latency: got %0d cycles want 8", n));
      checkOutput(done_o === 2'b01 && err_o === 1'b1 && rx_data_o === 8'h43,
                  $sformatf("t3_done: got done=%b err=%b rx=%h want 01 1 43", done_o, err_o, rx_data_o));
      tick();
      tick();
      receive_data_i = 1'b1;
      miso_data_i    = 8'hEE;
      tick();
      receive_data_i = 1'b0;
      checkOutput(done_o === 2'b00 && err_o === 1'b0 && rx_data_o === 8'h43 && busy_o === 1'b0,
                  $sformatf("t3_late_rx: got done=%b err=%b rx=%h busy=%b want 00 0 43 0",
                            done_o, err_o, rx_data_o, busy_o));
      timeout_i = 16'd0;
   endtask

   task automatic test_mode_drop();
      logic stray_gnt;
      stray_gnt = 1'b0;
      tx_data_i = {8'h5A, 8'h00};
      req_i     = 2'b10;
      tick();
      checkOutput(gnt_o === 2'b10 && mosi_data_o === 8'h5A,
                  $sformatf("t4_grant: got gnt=%b mosi=%h want 10 5a", gnt_o, mosi_data_o));
      req_i = 2'b00;
      tick();
      tick();
      spi_mode_i = 2'b01;
      spiswai_i  = 1'b1;
      tick();
      checkOutput(done_o === 2'b10 && err_o === 1'b1 && rx_data_o === 8'h43,
                  $sformatf("t4_abort: got done=%b err=%b rx=%h want 10 1 43", done_o, err_o, rx_data_o));
      req_i = 2'b11;
      repeat (6) begin
         tick();
         if (gnt_o !== 2'b00) stray_gnt = 1'b1;
      end
      checkOutput(!stray_gnt && busy_o === 1'b0,
                  $sformatf("t4_stopped: got stray_gnt=%b busy=%b want 0 0", stray_gnt, busy_o));
      spiswai_i = 1'b0;
      tx_data_i = {8'h5A, 8'h17};
      tick();
      checkOutput(gnt_o === 2'b01 && mosi_data_o === 8'h17,
                  $sformatf("t4_resume: got gnt=%b mosi=%h want 01 17", gnt_o, mosi_data_o));
      req_i = 2'b00;
      tick();
      receive_data_i = 1'b1;
      miso_data_i    = 8'h77;
      tick();
      receive_data_i = 1'b0;
      checkOutput(done_o === 2'b01 && err_o === 1'b0 && rx_data_o === 8'h77,
                  $sformatf("t4_done: got done=%b err=%b rx=%h want 01 0 77", done_o, err_o, rx_data_o));
      spi_mode_i = 2'b00;
      tick();
      tick();
   endtask

   task automatic test_collision();
      int n;
      gap_i     = 4'd3;
      tx_data_i = {8'h99, 8'h00};
      req_i     = 2'b10;
      tick();
      checkOutput(gnt_o === 2'b10 && mosi_data_o === 8'h99,
                  $sformatf("t5_grant: got gnt=%b mosi=%h want 10 99", gnt_o, mosi_data_o));
      req_i = 2'b00;
      tick();
      receive_data_i = 1'b1;
      miso_data_i    = 8'hC3;
      mstr_i         = 1'b0;
      tick();
      receive_data_i = 1'b0;
      mstr_i         = 1'b1;
      checkOutput(done_o === 2'b10 && err_o === 1'b0 && rx_data_o === 8'hC3,
                  $sformatf("t5_collision: got done=%b err=%b rx=%h want 10 0 c3", done_o, err_o, rx_data_o));
      n = 0;
      while (busy_o === 1'b1 && n < 10) begin
         tick();
         n++;
      end
      checkOutput(n == 4, $sformatf("t5_gap_len: got %0d gap cycles want 4", n));
      gap_i = 4'd0;
   endtask

   task automatic test_reset_mid_wait();
      tx_data_i = {8'h00, 8'hAB};
      req_i     = 2'b01;
      tick();
      checkOutput(gnt_o === 2'b01, $sformatf("t6_grant: got gnt=%b want 01", gnt_o));
      req_i = 2'b00;
      tick();
      tick();
      PRESET_n = 1'b0;
      #1;
      checkOutput({gnt_o, done_o, err_o, send_data_o, busy_o, rx_data_o, mosi_data_o} === 23'b0,
                  $sformatf("t6_reset_out: got gnt=%b done=%b err=%b send=%b busy=%b rx=%h mosi=%h want all 0",
                            gnt_o, done_o, err_o, send_data_o, busy_o, rx_data_o, mosi_data_o));
      tick();
      PRESET_n  = 1'b1;
      tx_data_i = {8'hCD, 8'hAB};
      req_i     = 2'b11;
      tick();
      checkOutput(gnt_o === 2'b01 && mosi_data_o === 8'hAB,
                  $sformatf("t6_ptr_reset: got gnt=%b mosi=%h want 01 ab", gnt_o, mosi_data_o));
      req_i = 2'b00;
      tick();
      receive_data_i = 1'b1;
      miso_data_i    = 8'h5E;
      tick();
      receive_data_i = 1'b0;
      checkOutput(done_o === 2'b01 && err_o === 1'b0 && rx_data_o === 8'h5E,
                  $sformatf("t6_done: got done=%b err=%b rx=%h want 01 0 5e", done_o, err_o, rx_data_o));
      tick();
      tick();
   endtask

   // Main sequence: run every directed test, then report the totals.
   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_mode_drop();
      test_collision();
      test_reset_mid_wait();
      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog against a hung simulation.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion want finish before 200us");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
